mem_read_router: RTL and testbench
==================================

Name: mem_read_router

Overview:
- Registered, parametrised read-data router for the 8-bit memory map.
- Accepts one read request at a time and decodes the address into ROM, RAM, input-port or unmapped regions.
- Waits the configured per-region latency, then returns one data word with a one-cycle valid pulse and an error flag.
- Sits between the CPU read path and the ROM, RAM and input-port blocks. It replaces the combinational data-out selection.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- ROM_END, 127, last ROM address; the ROM region is 0..ROM_END.
- RAM_BASE, 128, first RAM address.
- RAM_END, 223, last RAM address.
- PORT_BASE, 8'hF0, address of input port 0; port i is at PORT_BASE+i.
- NUM_PORTS, 2, number of input ports, legal range 1..16.
- ROM_LAT, 1, cycles from accept to ROM data capture, legal range 1..4.
- RAM_LAT, 1, cycles from accept to RAM data capture, legal range 1..4.
- UNMAPPED_DATA, 0, data returned for unmapped reads.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_req  in  1  read request; accepted when rd_ready=1 at the clock edge.
- rd_addr  in  ADDR_W  read address; sampled on accept.
- rd_ready  out  1  router can accept a request this cycle.
- mem_addr  out  ADDR_W  latched request address driven to ROM and RAM.
- rom_data_in  in  DATA_W  ROM read data.
- ram_data_in  in  DATA_W  RAM read data.
- port_in  in  NUM_PORTS*DATA_W  asynchronous input ports; port i occupies bits [i*DATA_W +: DATA_W].
- rd_valid  out  1  one-cycle response strobe.
- rd_data  out  DATA_W  response data; held until the next response.
- rd_err  out  1  response is for an unmapped address; qualified by rd_valid, held with rd_data.

Behaviour:
- Reset values, applied asynchronously: state=IDLE; rd_valid=0; rd_data=0; rd_err=0; mem_addr=0; latency counter=0; all synchroniser flops=0.
- Reset asserted mid-operation aborts the outstanding read. No response is produced for it.
- Port synchronisers: every port_in lane passes through a 2-flop synchroniser that updates every cycle. Port reads return the synchronised value.
- Decode, evaluated on the accepted address and complete over the whole address space (no held or undefined outputs):
  - ROM: addr <= ROM_END.
  - RAM: RAM_BASE <= addr <= RAM_END.
  - PORT i: addr == PORT_BASE+i, for i < NUM_PORTS.
  - UNMAPPED: everything else, e.g. 224..239, and any addr >= PORT_BASE+NUM_PORTS.
- Effective latency L: ROM uses ROM_LAT; RAM uses RAM_LAT; PORT and UNMAPPED use 1.
- State machine: IDLE, WAIT, RESP.
  - IDLE: rd_ready=1. On rd_req: latch mem_addr and region, load counter with L-1, go to WAIT.
  - WAIT: rd_ready=0. If counter != 0, decrement. If counter == 0, capture data from the selected source into rd_data, set rd_err=(region==UNMAPPED), set rd_valid=1, go to RESP.
  - RESP: rd_valid=1 for exactly this cycle; rd_ready=1. A rd_req here is accepted as in IDLE and goes to WAIT, giving back-to-back operation. With no request, go to IDLE. rd_valid clears on leaving RESP.
- Timing: accept at edge k, data captured at edge k+L, rd_valid high between edges k+L and k+L+1. Minimum issue interval is L+1 cycles.
- rd_req while rd_ready=0 is ignored (not queued). The requester must hold or re-issue it.
- mem_addr is stable from edge k until the next accept.
- Unmapped reads: rd_data=UNMAPPED_DATA, rd_err=1.
- Address arithmetic: PORT_BASE+i is computed at ADDR_W bits. Parameter sets where PORT_BASE+NUM_PORTS-1 exceeds 2^ADDR_W-1 are illegal and flagged by an elaboration check. Overlapping regions are also illegal. Priority on overlap is ROM > RAM > PORT.

Decomposition:
- Shared package mem_map_pkg holds:
  - region enum {REG_ROM, REG_RAM, REG_PORT, REG_UNMAPPED};
  - state enum {IDLE, WAIT, RESP};
  - default map constants ROM_END, RAM_BASE, RAM_END, PORT_BASE.
- One sub-module: sync_2ff, a parametrised DATA_W-wide 2-flop synchroniser with async active-high reset, instantiated once per port.

Test Plan:
- Reset, then read addr 8'h10 with rom_data_in=8'hA5, ROM_LAT=1 -> rd_valid high exactly one cycle, 1 cycle after accept; rd_data=8'hA5; rd_err=0; mem_addr=8'h10.
- RAM_LAT=3; read addr 8'h80 with ram_data_in=8'h3C -> rd_ready low for 3 cycles; rd_valid 3 cycles after accept; rd_data=8'h3C. Re-request in the RESP cycle is accepted (back-to-back).
- port_in lane1=8'h77, wait 3 cycles, read 8'hF1 -> rd_data=8'h77. Change lane1 to 8'h11 and read immediately -> rd_data=8'h77, showing the synchroniser delay.
- Read 8'hE0 and read 8'hF5 (NUM_PORTS=2) -> each returns rd_data=UNMAPPED_DATA(0) with rd_err=1. A following ROM read clears rd_err to 0.
- Issue a RAM read with RAM_LAT=3 and assert reset during WAIT -> outputs zero immediately and no rd_valid appears. After release, rd_ready=1 and a new read completes normally.
- Assert rd_req continuously while in WAIT with varying addresses -> only the accepted request responds. Ignored requests produce no response.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared types and default address map for the memory read path.
package mem_map_pkg;

  typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_PORT, REG_UNMAPPED} region_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int MAP_ROM_END   = 127;
  localparam int MAP_RAM_BASE  = 128;
  localparam int MAP_RAM_END   = 223;
  localparam int MAP_PORT_BASE = 'hF0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous multi-bit input lane.
module sync_2ff #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_read_router.sv
// Registered read router: decodes the address, waits the region latency,
// then returns one word with a single-cycle valid strobe.
module mem_read_router
  import mem_map_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int ROM_END       = MAP_ROM_END,
  parameter int RAM_BASE      = MAP_RAM_BASE,
  parameter int RAM_END       = MAP_RAM_END,
  parameter int PORT_BASE     = MAP_PORT_BASE,
  parameter int NUM_PORTS     = 2,
  parameter int ROM_LAT       = 1,
  parameter int RAM_LAT       = 1,
  parameter int UNMAPPED_DATA = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_req,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic                        rd_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           rom_data_in,
  input  logic [DATA_W-1:0]           ram_data_in,
  input  logic [NUM_PORTS*DATA_W-1:0] port_in,
  output logic                        rd_valid,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_err
);

  localparam int CNT_W = 2;

  if (NUM_PORTS < 1 || NUM_PORTS > 16 || ROM_LAT < 1 || ROM_LAT > 4 ||
      RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_range
    $fatal(1, "mem_read_router: NUM_PORTS or latency out of range");
  end
  if (ROM_END >= RAM_BASE || RAM_BASE > RAM_END || PORT_BASE <= ROM_END ||
      (PORT_BASE <= RAM_END && PORT_BASE + NUM_PORTS - 1 >= RAM_BASE) ||
      PORT_BASE + NUM_PORTS - 1 > (1 << ADDR_W) - 1) begin : g_bad_map
    $fatal(1, "mem_read_router: overlapping or out-of-range address map");
  end

  state_e              state_q, state_d;
  region_e             region_q, dec_region;
  logic [CNT_W-1:0]    cnt_q, dec_cnt;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   rd_data_q, port_data, src_data;
  logic                rd_valid_q, rd_err_q;
  logic                accept, capture;
  logic [NUM_PORTS-1:0][DATA_W-1:0] port_sync;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_sync
    sync_2ff #(.DATA_W(DATA_W)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (port_in[i*DATA_W +: DATA_W]),
      .q_o   (port_sync[i])
    );
  end

  // Ordered tests give ROM > RAM > PORT priority; anything left is unmapped.
  always_comb begin
    dec_region = REG_UNMAPPED;
    dec_cnt    = '0;
    if (int'(rd_addr) <= ROM_END) begin
      dec_region = REG_ROM;
      dec_cnt    = CNT_W'(ROM_LAT - 1);
    end else if (int'(rd_addr) >= RAM_BASE && int'(rd_addr) <= RAM_END) begin
      dec_region = REG_RAM;
      dec_cnt    = CNT_W'(RAM_LAT - 1);
    end else if (int'(rd_addr) >= PORT_BASE && int'(rd_addr) < PORT_BASE + NUM_PORTS) begin
      dec_region = REG_PORT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = accept ? WAIT : IDLE;
      WAIT:       if (cnt_q == '0) state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ready = (state_q != WAIT);
    accept   = rd_req && rd_ready;
    capture  = (state_q == WAIT) && (cnt_q == '0);
  end

  always_comb begin
    port_data = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (int'(mem_addr_q) == PORT_BASE + i) port_data = port_sync[i];
  end

  always_comb begin
    case (region_q)
      REG_ROM:  src_data = rom_data_in;
      REG_RAM:  src_data = ram_data_in;
      REG_PORT: src_data = port_data;
      default:  src_data = DATA_W'(UNMAPPED_DATA);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_q <= '0;
      region_q   <= REG_ROM;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= capture;
      if (accept) begin
        mem_addr_q <= rd_addr;
        region_q   <= dec_region;
        cnt_q      <= dec_cnt;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) begin
        rd_data_q <= src_data;
        rd_err_q  <= (region_q == REG_UNMAPPED);
      end
    end
  end

  assign mem_addr = mem_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_mem_read_router.sv
// Scoreboard bench for mem_read_router: stimulus pushes expected responses,
// a negedge monitor pops and checks data, error flag and arrival cycle.
module tb_mem_read_router;

  localparam int RAM_L = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [7:0]  rom_data_in = 8'hA5;
  logic [7:0]  ram_data_in = 8'h3C;
  logic [15:0] port_in = '0;
  logic        rd_ready, rd_valid, rd_err;
  logic [7:0]  mem_addr, rd_data;

  mem_read_router #(.RAM_LAT(RAM_L)) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ready    (rd_ready),
    .mem_addr    (mem_addr),
    .rom_data_in (rom_data_in),
    .ram_data_in (ram_data_in),
    .port_in     (port_in),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_err      (rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && rd_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious rd_valid: got data %0h err %0b with nothing outstanding", rd_data, rd_err);
      end else begin
        e = sb.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_err", rd_err, e.err);
        check("valid cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one read at a negedge once rd_ready is seen; waited = negedges spent waiting.
  task automatic issue(input logic [7:0] addr, input int lat, input logic [7:0] d,
                       input logic e, output int waited);
    exp_t x;
    waited = 0;
    while (!rd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("rd_ready before issue", rd_ready, 1);
    rd_req  = 1'b1;
    rd_addr = addr;
    x.data  = d;
    x.err   = e;
    x.cyc   = cyc + 1 + lat;
    sb.push_back(x);
    @(negedge clk);
    rd_req = 1'b0;
    check("mem_addr after accept", mem_addr, addr);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("outstanding after drain", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    #1;
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 0);
    check("reset rd_err", rd_err, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset rd_ready", rd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ROM read, latency 1
    issue(8'h10, 1, 8'hA5, 1'b0, w);
    drain();

    // RAM read latency 3, second request issued in the RESP cycle
    issue(8'h80, RAM_L, 8'h3C, 1'b0, w);
    issue(8'h81, RAM_L, 8'h3C, 1'b0, w);
    check("ready-low cycles before back-to-back", w, 3);
    drain();

    // Input ports through the synchroniser
    port_in[15:8] = 8'h77;
    port_in[7:0]  = 8'h5A;
    repeat (3) @(negedge clk);
    issue(8'hF1, 1, 8'h77, 1'b0, w);
    drain();
    port_in[15:8] = 8'h11;
    issue(8'hF1, 1, 8'h77, 1'b0, w);
    drain();
    issue(8'hF1, 1, 8'h11, 1'b0, w);
    issue(8'hF0, 1, 8'h5A, 1'b0, w);
    drain();

    // Unmapped and region boundaries
    issue(8'hE0, 1, 8'h00, 1'b1, w);
    issue(8'hF5, 1, 8'h00, 1'b1, w);
    issue(8'hF2, 1, 8'h00, 1'b1, w);
    issue(8'hDF, RAM_L, 8'h3C, 1'b0, w);
    issue(8'hFF, 1, 8'h00, 1'b1, w);
    issue(8'h7F, 1, 8'hA5, 1'b0, w);
    drain();

    // Requests held during WAIT are ignored
    issue(8'h90, RAM_L, 8'h3C, 1'b0, w);
    rd_req  = 1'b1;
    rd_addr = 8'hE0;
    @(negedge clk);
    rd_addr = 8'h10;
    @(negedge clk);
    rd_req = 1'b0;
    check("mem_addr held in WAIT", mem_addr, 8'h90);
    drain();
    repeat (4) @(negedge clk);

    // Reset during WAIT aborts the read
    issue(8'h85, RAM_L, 8'h3C, 1'b0, w);
    reset = 1'b1;
    sb.delete();
    #1;
    check("abort rd_valid", rd_valid, 0);
    check("abort rd_data", rd_data, 0);
    check("abort rd_err", rd_err, 0);
    check("abort mem_addr", mem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rd_ready after reset", rd_ready, 1);
    repeat (5) @(negedge clk);
    issue(8'h20, 1, 8'hA5, 1'b0, w);
    drain();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
